// File: rtl/sega_pad_reader.sv
// Sega Genesis (3-button) pad reader.
//
// Once per poll period the FSM drives SELECT high, waits for the pad to settle and captures
// {C,B,Right,Left,Down,Up}. It then drives SELECT low, waits again and captures {Start,A}
// together with the Genesis ID pins. On the cycle after the frame the results are published
// with a one-cycle valid pulse.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   en         polling enable; sampled only when a frame would start
//   pad_in     raw DB9 pins {p9,p6,p4,p3,p2,p1}, active-low, asynchronous to clk
//   select     DB9 pin 7 drive to the pad
//   btn        {start,a,c,b,right,left,down,up}, active-high
//   present    last frame identified a Genesis pad
//   valid      one-cycle pulse when btn/present update
//   start_rise one-cycle pulse with valid when btn[7] goes 0->1
module sega_pad_reader #(
  parameter int unsigned SETTLE_CYCLES = 250,
  parameter int unsigned POLL_CYCLES   = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [5:0] pad_in,
  output logic       select,
  output logic [7:0] btn,
  output logic       present,
  output logic       valid,
  output logic       start_rise
);

  localparam int unsigned PollW   = $clog2(POLL_CYCLES);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES);

  localparam logic [PollW-1:0]   PollLast   = PollW'(POLL_CYCLES - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHiWait, StLoWait, StUpdate} state_e;

  state_e             state_q;
  logic [5:0]         sync1_q, sync2_q;
  logic [PollW-1:0]   poll_cnt_q;
  logic [SettleW-1:0] phase_q;
  logic [5:0]         hi_q;          // {c,b,right,left,down,up}, active-high
  logic [1:0]         lo_q;          // {start,a}, active-high
  logic               lo_present_q;
  logic               select_q;
  logic [7:0]         btn_q;
  logic               present_q;
  logic               valid_q;
  logic               start_rise_q;
  logic               poll_tick;
  logic [7:0]         new_btn;

  assign poll_tick = (poll_cnt_q == PollLast);

  // A pad that does not pull p3/p4 low in the low phase is not a Genesis pad: report no buttons.
  always_comb begin
    new_btn = 8'h00;
    if (lo_present_q) begin
      new_btn = {lo_q, hi_q};
    end
  end

  // Two-flop synchronizer; idle (released) pins read as ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 6'h3F;
      sync2_q <= 6'h3F;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt_q <= '0;
    end else if (poll_tick) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_q + PollW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      lo_present_q <= 1'b0;
      select_q     <= 1'b1;
      btn_q        <= 8'h00;
      present_q    <= 1'b0;
      valid_q      <= 1'b0;
      start_rise_q <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      start_rise_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          phase_q <= '0;
          if (poll_tick && en) begin
            state_q <= StHiWait;
          end
        end
        StHiWait: begin
          if (phase_q == SettleLast) begin
            hi_q     <= ~sync2_q;
            phase_q  <= '0;
            select_q <= 1'b0;
            state_q  <= StLoWait;
          end else begin
            phase_q <= phase_q + SettleW'(1);
          end
        end
        StLoWait: begin
          if (phase_q == SettleLast) begin
            lo_q         <= ~sync2_q[5:4];
            lo_present_q <= (sync2_q[3:2] == 2'b00);
            phase_q      <= '0;
            select_q     <= 1'b1;
            state_q      <= StUpdate;
          end else begin
            phase_q <= phase_q + SettleW'(1);
          end
        end
        StUpdate: begin
          btn_q        <= new_btn;
          present_q    <= lo_present_q;
          valid_q      <= 1'b1;
          start_rise_q <= new_btn[7] & ~btn_q[7];
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign select     = select_q;
  assign btn        = btn_q;
  assign present    = present_q;
  assign valid      = valid_q;
  assign start_rise = start_rise_q;

endmodule

// File: tb/tb_sega_pad_reader.sv
// Self-checking bench for sega_pad_reader with SETTLE_CYCLES=4, POLL_CYCLES=32.
// A pad model drives the pins from select; a frame-level model predicts when each frame
// runs, when select is low, and what btn/present/start_rise must read at each valid.
module tb_sega_pad_reader;

  localparam int S = 4;
  localparam int P = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [5:0] pad_in;
  logic       select;
  logic [7:0] btn;
  logic       present;
  logic       valid;
  logic       start_rise;

  logic [5:0] hi_val;
  logic [5:0] lo_val;

  int tests = 0;
  int failures = 0;
  int cyc = 0;

  // Frame model: tick cycle of the frame in flight (-1 if none) and the pad levels it reads.
  int         cur_tick = -1;
  logic [5:0] fr_hi, fr_lo;
  logic [7:0] exp_btn = 8'h00;
  logic       exp_present = 1'b0;

  always #5 clk = ~clk;

  assign pad_in = select ? hi_val : lo_val;

  sega_pad_reader #(
    .SETTLE_CYCLES(S),
    .POLL_CYCLES  (P)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .pad_in    (pad_in),
    .select    (select),
    .btn       (btn),
    .present   (present),
    .valid     (valid),
    .start_rise(start_rise)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Check the current cycle against the model, register a new frame on an enabled tick,
  // then advance to the next negedge.
  task automatic step();
    logic       exp_valid, exp_sel, exp_sr, pres;
    logic [7:0] nb;
    exp_valid = (cur_tick >= 0) && (cyc == cur_tick + 2 * S + 2);
    exp_sel   = !((cur_tick >= 0) && (cyc >= cur_tick + S + 1) && (cyc <= cur_tick + 2 * S));
    exp_sr    = 1'b0;
    if (exp_valid) begin
      pres        = (fr_lo[3:2] == 2'b00);
      nb          = pres ? {~fr_lo[5], ~fr_lo[4], ~fr_hi} : 8'h00;
      exp_sr      = nb[7] & ~exp_btn[7];
      exp_btn     = nb;
      exp_present = pres;
      cur_tick    = -1;
    end
    check("valid", 32'(valid), 32'(exp_valid));
    check("select", 32'(select), 32'(exp_sel));
    check("start_rise", 32'(start_rise), 32'(exp_sr));
    check("btn", 32'(btn), 32'(exp_btn));
    check("present", 32'(present), 32'(exp_present));
    if ((cyc % P == P - 1) && en && (cur_tick < 0)) begin
      cur_tick = cyc;
      fr_hi    = hi_val;
      fr_lo    = lo_val;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_mod(input int m);
    while (cyc % P != m) step();
  endtask

  // Advance whole poll periods, landing on a quiet point between frames.
  task automatic periods(input int n);
    repeat (n) begin
      step();
      wait_mod(15);
    end
  endtask

  task automatic release_reset();
    reset       = 1'b0;
    cyc         = 0;
    cur_tick    = -1;
    exp_btn     = 8'h00;
    exp_present = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    hi_val = 6'h3F;
    lo_val = 6'h33;
    repeat (2) @(negedge clk);
    check("rst_select", 32'(select), 32'd1);
    check("rst_btn", 32'(btn), 32'd0);
    check("rst_present", 32'(present), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_start_rise", 32'(start_rise), 32'd0);

    // No buttons pressed.
    release_reset();
    wait_mod(15);
    periods(3);

    // Start + Up held over several frames: start_rise only on the first.
    hi_val = 6'h3E;
    lo_val = 6'h13;
    periods(3);

    // Disconnected pad.
    hi_val = 6'h3F;
    lo_val = 6'h3F;
    periods(2);

    // Polling disabled for three periods, then resumed.
    hi_val = 6'h3E;
    lo_val = 6'h13;
    en     = 1'b0;
    periods(3);
    en = 1'b1;
    periods(2);

    // Random pad states and enables.
    for (int i = 0; i < 10; i++) begin
      hi_val = 6'($urandom);
      lo_val = 6'($urandom);
      if ($urandom_range(3) != 0) lo_val[3:2] = 2'b00;
      en = ($urandom_range(4) != 0);
      periods(1);
    end
    en = 1'b1;

    // Pins change one cycle before each capture point: the old levels must be captured.
    hi_val = 6'h3F;
    lo_val = 6'h33;
    wait_mod(P - 1);
    repeat (S - 1) step();
    hi_val = 6'h30;
    repeat (S) step();
    lo_val = 6'h03;
    periods(2);

    // Reset in the middle of the low phase.
    hi_val = 6'h3E;
    lo_val = 6'h13;
    wait_mod(P - 1);
    repeat (S + 2) step();
    reset = 1'b1;
    #1;
    check("midrst_select", 32'(select), 32'd1);
    check("midrst_btn", 32'(btn), 32'd0);
    check("midrst_present", 32'(present), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("inrst_valid", 32'(valid), 32'd0);
      check("inrst_select", 32'(select), 32'd1);
    end
    release_reset();
    wait_mod(15);
    periods(3);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
